// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the reset vector, the NOP
// word, the FSM state encodings, the fault-cause codes and an alignment helper.
package inst_fetch_pkg;

   localparam logic [31:0] zero_word    = 32'h0000_0000;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [2:0] {
      IF_IDLE  = 3'd0,
      IF_REQ   = 3'd1,
      IF_WAIT  = 3'd2,
      IF_HOLD  = 3'd3,
      IF_FAULT = 3'd4
   } if_state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_MISALIGN = 2'd1,
      FC_BUS_ERR  = 2'd2,
      FC_TIMEOUT  = 2'd3
   } fault_cause_e;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter for the fetch response timeout. `expired` flags the
// enabled cycle on which the count reaches LIMIT, so the caller can act on that edge.
module fetch_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
   localparam logic [CW-1:0] MAX  = CW'(LIMIT);

   logic [CW-1:0] cnt_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of its sources.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word request per PC, holds the returned
// instruction until acknowledged and parks in a sticky fault state on any error.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_in,
   output logic        pc_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        inst_ack,
   output logic        fetch_err,
   output logic [1:0]  fault_cause
);

   if_state_e    state_q, state_d;
   fault_cause_e fault_q;
   logic [31:0]  inst_q;
   logic [31:0]  inst_pc_q;

   logic aligned;
   logic req_fire;
   logic rsp_ok;
   logic rsp_bad;
   logic tmr_en;
   logic tmr_expired;

   assign aligned  = is_aligned(pc_in);
   assign req_fire = imem_req_valid & imem_req_ready;
   assign rsp_ok   = (state_q == IF_WAIT) & imem_rsp_valid & ~imem_rsp_err;
   assign rsp_bad  = (state_q == IF_WAIT) & imem_rsp_valid &  imem_rsp_err;
   // A response on the last counted cycle suppresses the tick, so it wins over the timeout.
   assign tmr_en   = (state_q == IF_WAIT) & ~imem_rsp_valid;

   fetch_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (req_fire),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IF_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default before the case statement,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IF_IDLE: state_d = IF_REQ;
         IF_REQ: begin
            if (!aligned) begin
               state_d = IF_FAULT;
            end else if (imem_req_ready) begin
               state_d = IF_WAIT;
            end
         end
         IF_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = imem_rsp_err ? IF_FAULT : IF_HOLD;
            end else if (tmr_expired) begin
               state_d = IF_FAULT;
            end
         end
         IF_HOLD: begin
            if (inst_ack) begin
               state_d = IF_REQ;
            end
         end
         IF_FAULT: state_d = IF_FAULT;
         default:  state_d = IF_IDLE;
      endcase
   end

   always_comb begin
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
      fetch_err      = 1'b0;
      pc_en          = 1'b0;
      case (state_q)
         IF_REQ:   imem_req_valid = aligned;
         IF_HOLD: begin
            inst_valid = 1'b1;
            pc_en      = inst_ack;
         end
         IF_FAULT: begin
            inst_valid = 1'b1;
            fetch_err  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inst_q    <= NOP_INST;
         inst_pc_q <= zero_word + RESET_VECTOR;
         fault_q   <= FC_NONE;
      end else begin
         if (req_fire) begin
            inst_pc_q <= pc_in;
         end
         if (rsp_ok) begin
            inst_q <= imem_rsp_data;
         end
         if ((state_q == IF_REQ) && !aligned) begin
            fault_q <= FC_MISALIGN;
         end else if (rsp_bad) begin
            fault_q <= FC_BUS_ERR;
         end else if (tmr_expired) begin
            fault_q <= FC_TIMEOUT;
         end
      end
   end

   assign imem_req_addr = pc_in;
   assign inst_out      = (state_q == IF_FAULT) ? NOP_INST : inst_q;
   assign inst_pc       = inst_pc_q;
   assign fault_cause   = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: scripted fetch transactions with random timing and stray
// events; expected outputs per cycle come from each transaction's timeline.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int TO = 8;

   logic        clk;
   logic        rstn;
   logic [31:0] pc_in;
   logic        pc_en;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ack;
   logic        fetch_err;
   logic [1:0]  fault_cause;

   inst_fetch #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .pc_in          (pc_in),
      .pc_en          (pc_en),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .inst_ack       (inst_ack),
      .fetch_err      (fetch_err),
      .fault_cause    (fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req_valid;
      logic [31:0] req_addr;
      logic        inst_valid;
      logic [31:0] inst_out;
      logic [31:0] inst_pc;
      logic        cmp_pc;
      logic        pc_en;
      logic        fetch_err;
      logic [1:0]  cause;
   } exp_t;

   exp_t        want;
   logic        chk_on;
   logic [31:0] pc;        // model of the upstream PC register
   logic [1:0]  cause_m;   // fault cause the block should be reporting
   int          n_pass;
   int          n_total;

   assign pc_in = pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("req_valid", {31'b0, imem_req_valid}, {31'b0, want.req_valid});
         if (want.req_valid) check("req_addr", imem_req_addr, want.req_addr);
         check("inst_valid", {31'b0, inst_valid}, {31'b0, want.inst_valid});
         if (want.inst_valid) check("inst_out", inst_out, want.inst_out);
         if (want.inst_valid && want.cmp_pc) check("inst_pc", inst_pc, want.inst_pc);
         check("pc_en", {31'b0, pc_en}, {31'b0, want.pc_en});
         check("fetch_err", {31'b0, fetch_err}, {31'b0, want.fetch_err});
         check("fault_cause", {30'b0, fault_cause}, {30'b0, want.cause});
      end
   end

   function automatic exp_t base();
      exp_t e;
      e.req_valid  = 1'b0;
      e.req_addr   = '0;
      e.inst_valid = 1'b0;
      e.inst_out   = '0;
      e.inst_pc    = '0;
      e.cmp_pc     = 1'b0;
      e.pc_en      = 1'b0;
      e.fetch_err  = 1'b0;
      e.cause      = cause_m;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random activity on every input; phases override what matters to them.
   task automatic noise();
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = ($urandom_range(0, 3) == 0);
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom_range(0, 1));
      inst_ack       = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rstn           = 1'b0;
      pc             = RESET_VECTOR;
      cause_m        = 2'd0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      inst_ack       = 1'b0;
      want           = base();
      chk_on         = 1'b1;
      #1;
      check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst inst_out", inst_out, 32'h0000_0013);
      check("rst inst_pc", inst_pc, 32'h0000_1000);
      check("rst fetch_err", {31'b0, fetch_err}, 32'd0);
      check("rst fault_cause", {30'b0, fault_cause}, 32'd0);
      tick();
      noise();
      tick();
      rstn = 1'b1;
      noise();
      want = base();
      tick();
   endtask

   task automatic req_phase(input int rd);
      for (int i = 0; i <= rd; i++) begin
         noise();
         imem_req_ready = (i == rd);
         want           = base();
         want.req_valid = 1'b1;
         want.req_addr  = pc;
         tick();
      end
   endtask

   // lat = WAIT cycle carrying the response (1 = earliest); 0 = never responds.
   task automatic wait_phase(input int lat, input logic err, input logic [31:0] data);
      int n;
      n = (lat == 0) ? TO : lat;
      for (int j = 1; j <= n; j++) begin
         noise();
         if ((lat != 0) && (j == lat)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_err   = err;
            imem_rsp_data  = data;
         end else begin
            imem_rsp_valid = 1'b0;
         end
         want = base();
         tick();
      end
      if (lat == 0) cause_m = 2'd3;
      else if (err) cause_m = 2'd2;
   endtask

   task automatic stall_phase(input int k);
      for (int j = 0; j < k; j++) begin
         noise();
         imem_rsp_valid = 1'b0;
         want = base();
         tick();
      end
   endtask

   task automatic hold_phase(input int ad, input logic [31:0] data, input logic [31:0] next_pc);
      for (int k = 1; k <= ad; k++) begin
         noise();
         inst_ack        = (k == ad);
         want            = base();
         want.inst_valid = 1'b1;
         want.inst_out   = data;
         want.inst_pc    = pc;
         want.cmp_pc     = 1'b1;
         want.pc_en      = (k == ad);
         tick();
      end
      pc = next_pc;
   endtask

   task automatic misalign_phase();
      noise();
      want = base();
      tick();
      cause_m = 2'd1;
   endtask

   task automatic fault_phase(input int n);
      for (int k = 0; k < n; k++) begin
         noise();
         want            = base();
         want.inst_valid = 1'b1;
         want.inst_out   = NOP_INST;
         want.fetch_err  = 1'b1;
         tick();
      end
   endtask

   initial begin
      int          nf;
      int          kind;
      logic [31:0] d;
      logic [31:0] np;

      n_pass         = 0;
      n_total        = 0;
      chk_on         = 1'b0;
      rstn           = 1'b1;
      pc             = RESET_VECTOR;
      cause_m        = 2'd0;
      want           = base();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      inst_ack       = 1'b0;
      tick();

      // First fetch from the reset vector with the fastest memory.
      do_reset();
      check("first req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("first req_addr", imem_req_addr, 32'h0000_1000);
      req_phase(0);
      wait_phase(1, 1'b0, 32'h0010_0093);
      check("first inst_valid", {31'b0, inst_valid}, 32'd1);
      check("first inst_out", inst_out, 32'h0010_0093);
      check("first inst_pc", inst_pc, 32'h0000_1000);
      hold_phase(1, 32'h0010_0093, 32'h0000_1004);

      // Backpressure on the request, slow response, long hold, latency == TIMEOUT.
      req_phase(4);
      wait_phase(7, 1'b0, 32'h0020_8113);
      hold_phase(2, 32'h0020_8113, 32'h0000_1008);
      req_phase(1);
      wait_phase(2, 1'b0, 32'hcafe_f00d);
      hold_phase(11, 32'hcafe_f00d, 32'h0000_100c);
      req_phase(0);
      wait_phase(TO, 1'b0, 32'h1234_5678);
      hold_phase(1, 32'h1234_5678, 32'h8000_0002);

      // Misaligned PC.
      misalign_phase();
      check("misalign fetch_err", {31'b0, fetch_err}, 32'd1);
      check("misalign cause", {30'b0, fault_cause}, 32'd1);
      check("misalign inst_out", inst_out, 32'h0000_0013);
      fault_phase(5);

      // Bus error.
      do_reset();
      req_phase(2);
      wait_phase(3, 1'b1, 32'hffff_ffff);
      check("buserr cause", {30'b0, fault_cause}, 32'd2);
      fault_phase(3);

      // Timeout TO cycles after accept.
      do_reset();
      req_phase(0);
      wait_phase(0, 1'b0, 32'h0);
      check("timeout cause", {30'b0, fault_cause}, 32'd3);
      check("timeout fetch_err", {31'b0, fetch_err}, 32'd1);
      fault_phase(4);

      // Reset in the middle of WAIT, then restart from the reset vector.
      do_reset();
      req_phase(1);
      stall_phase(3);
      do_reset();
      check("restart req_addr", imem_req_addr, 32'h0000_1000);
      req_phase(0);
      wait_phase(2, 1'b0, 32'h0000_0113);
      hold_phase(1, 32'h0000_0113, 32'h0000_1004);

      // Random episodes, each closing with a random ending.
      for (int e = 0; e < 40; e++) begin
         nf   = $urandom_range(2, 6);
         kind = $urandom_range(0, 4);
         do_reset();
         for (int f = 0; f < nf; f++) begin
            d  = $urandom;
            np = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : (pc + 32'd4);
            if ((f == nf - 1) && (kind == 1)) begin
               np      = $urandom;
               np[1:0] = 2'($urandom_range(1, 3));
            end
            req_phase($urandom_range(0, 3));
            wait_phase($urandom_range(1, TO), 1'b0, d);
            hold_phase($urandom_range(1, 4), d, np);
         end
         case (kind)
            1: begin
               misalign_phase();
               fault_phase(4);
            end
            2: begin
               req_phase($urandom_range(0, 3));
               wait_phase($urandom_range(1, TO), 1'b1, $urandom);
               fault_phase(4);
            end
            3: begin
               req_phase($urandom_range(0, 3));
               wait_phase(0, 1'b0, 32'h0);
               fault_phase(3);
            end
            4: begin
               req_phase($urandom_range(0, 3));
               stall_phase($urandom_range(1, TO - 1));
            end
            default: ;
         endcase
      end

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
